// File: rtl/fsm_reach_monitor.sv
// Parametrised gated-toggle/counter/shift state machine with target reachability tracking:
// a combinational hit flag, sticky reached flag, first-hit cycle stamp and saturating counters.
module fsm_reach_monitor #(
   parameter int unsigned      WIDTH      = 2,
   parameter int unsigned      MODE       = 0,
   parameter int unsigned      CW         = 16,
   parameter logic [WIDTH-1:0] INIT_STATE = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             a,
   input  logic             load,
   input  logic [WIDTH-1:0] load_state,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] state,
   output logic             hit,
   output logic             reached,
   output logic [CW-1:0]    first_hit_cycles,
   output logic [CW-1:0]    hit_count,
   output logic [CW-1:0]    cycle_count
);

   localparam int unsigned UW = WIDTH - 1;

   if (WIDTH < 2) begin : g_bad_width
      $error("fsm_reach_monitor: WIDTH must be >= 2");
   end
   if (MODE > 2) begin : g_bad_mode
      $error("fsm_reach_monitor: MODE must be 0, 1 or 2");
   end

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] next_state;
   logic             bit0_next;
   logic             reached_q, reached_d;
   logic [CW-1:0]    cycle_count_q, cycle_count_d;
   logic [CW-1:0]    hit_count_q, hit_count_d;
   logic [CW-1:0]    first_hit_q, first_hit_d;

   assign bit0_next = ~(a & state_q[0]);

   // Upper-bit rule is fixed at elaboration; bit 0 is common to every mode.
   if (MODE == 0) begin : g_toggle
      assign next_state = {~state_q[WIDTH-1:1], bit0_next};
   end else if (MODE == 1) begin : g_counter
      assign next_state = {state_q[WIDTH-1:1] + UW'(1), bit0_next};
   end else begin : g_shift
      assign next_state = {state_q[WIDTH-2:0], bit0_next};
   end

   assign hit = (state_q == target);

   always_comb begin
      state_d       = state_q;
      reached_d     = reached_q;
      cycle_count_d = cycle_count_q;
      hit_count_d   = hit_count_q;
      first_hit_d   = first_hit_q;
      if (load) begin
         state_d       = load_state;
         reached_d     = 1'b0;
         cycle_count_d = '0;
         hit_count_d   = '0;
         first_hit_d   = '0;
      end else if (en) begin
         state_d = next_state;
         if (cycle_count_q != '1) begin
            cycle_count_d = cycle_count_q + CW'(1);
         end
         // Hit is judged on the pre-edge state; the stamp is the pre-edge cycle count.
         if (hit) begin
            if (hit_count_q != '1) begin
               hit_count_d = hit_count_q + CW'(1);
            end
            if (!reached_q) begin
               first_hit_d = cycle_count_q;
               reached_d   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= INIT_STATE;
         reached_q     <= 1'b0;
         cycle_count_q <= '0;
         hit_count_q   <= '0;
         first_hit_q   <= '0;
      end else begin
         state_q       <= state_d;
         reached_q     <= reached_d;
         cycle_count_q <= cycle_count_d;
         hit_count_q   <= hit_count_d;
         first_hit_q   <= first_hit_d;
      end
   end

   assign state            = state_q;
   assign reached          = reached_q;
   assign first_hit_cycles = first_hit_q;
   assign hit_count        = hit_count_q;
   assign cycle_count      = cycle_count_q;

endmodule

// File: tb/tb_fsm_reach_monitor.sv
// Scoreboard bench for fsm_reach_monitor: five instances (legacy, counter, shift, saturating,
// load/hold) share clock and reset; expectations are queued and drained by a monitor process.
module tb_fsm_reach_monitor;

   localparam int F_ST  = 0;
   localparam int F_HIT = 1;
   localparam int F_RCH = 2;
   localparam int F_FH  = 3;
   localparam int F_HC  = 4;
   localparam int F_CC  = 5;

   typedef struct {
      string       name;
      int          dut;
      int          fld;
      logic [15:0] exp;
   } exp_t;

   logic clock;
   logic reset;

   logic       en_r [5];
   logic       a_r  [5];
   logic       ld_r [5];
   logic [3:0] ls_r [5];
   logic [3:0] tg_r [5];

   logic [1:0]  st0;
   logic [3:0]  fh3, hc3, cc3;
   logic [3:0]  st_w  [5];
   logic        hit_w [5];
   logic        rch_w [5];
   logic [15:0] fh_w  [5];
   logic [15:0] hc_w  [5];
   logic [15:0] cc_w  [5];

   assign st_w[0] = {2'b00, st0};
   assign fh_w[3] = {12'd0, fh3};
   assign hc_w[3] = {12'd0, hc3};
   assign cc_w[3] = {12'd0, cc3};

   exp_t sb[$];
   int   checks;
   int   failures;
   event chk_ev;

   fsm_reach_monitor #(.WIDTH(2), .MODE(0), .CW(16), .INIT_STATE(2'b00)) u_legacy (
      .clock(clock), .reset(reset), .en(en_r[0]), .a(a_r[0]), .load(ld_r[0]),
      .load_state(ls_r[0][1:0]), .target(tg_r[0][1:0]), .state(st0), .hit(hit_w[0]),
      .reached(rch_w[0]), .first_hit_cycles(fh_w[0]), .hit_count(hc_w[0]),
      .cycle_count(cc_w[0])
   );

   fsm_reach_monitor #(.WIDTH(4), .MODE(1), .CW(16), .INIT_STATE(4'b0000)) u_counter (
      .clock(clock), .reset(reset), .en(en_r[1]), .a(a_r[1]), .load(ld_r[1]),
      .load_state(ls_r[1]), .target(tg_r[1]), .state(st_w[1]), .hit(hit_w[1]),
      .reached(rch_w[1]), .first_hit_cycles(fh_w[1]), .hit_count(hc_w[1]),
      .cycle_count(cc_w[1])
   );

   fsm_reach_monitor #(.WIDTH(4), .MODE(2), .CW(16), .INIT_STATE(4'b0000)) u_shift (
      .clock(clock), .reset(reset), .en(en_r[2]), .a(a_r[2]), .load(ld_r[2]),
      .load_state(ls_r[2]), .target(tg_r[2]), .state(st_w[2]), .hit(hit_w[2]),
      .reached(rch_w[2]), .first_hit_cycles(fh_w[2]), .hit_count(hc_w[2]),
      .cycle_count(cc_w[2])
   );

   fsm_reach_monitor #(.WIDTH(4), .MODE(0), .CW(4), .INIT_STATE(4'b0000)) u_sat (
      .clock(clock), .reset(reset), .en(en_r[3]), .a(a_r[3]), .load(ld_r[3]),
      .load_state(ls_r[3]), .target(tg_r[3]), .state(st_w[3]), .hit(hit_w[3]),
      .reached(rch_w[3]), .first_hit_cycles(fh3), .hit_count(hc3), .cycle_count(cc3)
   );

   fsm_reach_monitor #(.WIDTH(4), .MODE(0), .CW(16), .INIT_STATE(4'b0000)) u_hold (
      .clock(clock), .reset(reset), .en(en_r[4]), .a(a_r[4]), .load(ld_r[4]),
      .load_state(ls_r[4]), .target(tg_r[4]), .state(st_w[4]), .hit(hit_w[4]),
      .reached(rch_w[4]), .first_hit_cycles(fh_w[4]), .hit_count(hc_w[4]),
      .cycle_count(cc_w[4])
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [15:0] get_out(int d, int f);
      case (f)
         F_ST:    return {12'd0, st_w[d]};
         F_HIT:   return {15'd0, hit_w[d]};
         F_RCH:   return {15'd0, rch_w[d]};
         F_FH:    return fh_w[d];
         F_HC:    return hc_w[d];
         default: return cc_w[d];
      endcase
   endfunction

   function automatic logic [3:0] tog4(logic [3:0] s, logic ai);
      return {~s[3:1], ~(ai & s[0])};
   endfunction

   // Monitor: drains every queued expectation each time the stimulus presents a sample point.
   initial begin
      exp_t        e;
      logic [15:0] got;
      forever begin
         @(chk_ev);
         while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = get_out(e.dut, e.fld);
            checks++;
            if (got !== e.exp) begin
               failures++;
               $display("FAIL %s (dut%0d) got=%0h expected=%0h", e.name, e.dut, got, e.exp);
            end
         end
      end
   end

   task automatic expect_v(string name, int dut, int fld, logic [15:0] v);
      exp_t e;
      e.name = name;
      e.dut  = dut;
      e.fld  = fld;
      e.exp  = v;
      sb.push_back(e);
   endtask

   task automatic flush();
      -> chk_ev;
      #1;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   logic [3:0] cnt_seq [8];
   logic [3:0] m;

   initial begin
      checks   = 0;
      failures = 0;
      cnt_seq  = '{4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF, 4'h1};
      reset    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         en_r[i] = 1'b0;
         a_r[i]  = 1'b0;
         ld_r[i] = 1'b0;
         ls_r[i] = 4'h0;
      end
      tg_r[0] = 4'b0010;
      tg_r[1] = 4'b0000;
      tg_r[2] = 4'b0101;
      tg_r[3] = 4'b0010;
      tg_r[4] = 4'b1111;
      #12;
      for (int d = 0; d < 5; d++) begin
         expect_v("reset_state", d, F_ST, 16'd0);
         expect_v("reset_reached", d, F_RCH, 16'd0);
         expect_v("reset_cycles", d, F_CC, 16'd0);
         expect_v("reset_hits", d, F_HC, 16'd0);
      end
      expect_v("reset_hit_comb", 1, F_HIT, 16'd1);
      flush();
      reset = 1'b0;

      // Legacy 2-bit path: 00 -> 11 -> 01 -> 10, hit counted on the following edge.
      en_r[0] = 1'b1;
      step(); expect_v("legacy_s1", 0, F_ST, 16'd3); flush();
      step(); expect_v("legacy_s2", 0, F_ST, 16'd1); flush();
      a_r[0] = 1'b1;
      step();
      expect_v("legacy_s3", 0, F_ST, 16'd2);
      expect_v("legacy_hit", 0, F_HIT, 16'd1);
      expect_v("legacy_not_yet_reached", 0, F_RCH, 16'd0);
      expect_v("legacy_cc3", 0, F_CC, 16'd3);
      flush();
      step();
      expect_v("legacy_reached", 0, F_RCH, 16'd1);
      expect_v("legacy_first_hit", 0, F_FH, 16'd3);
      expect_v("legacy_hit_count", 0, F_HC, 16'd1);
      expect_v("legacy_cc4", 0, F_CC, 16'd4);
      expect_v("legacy_s4", 0, F_ST, 16'd1);
      expect_v("legacy_hit_low", 0, F_HIT, 16'd0);
      flush();
      checks++;
      if (rch_w[0] !== 1'b1) begin
         failures++;
         $display("FAIL direct_legacy_reached got=%0b expected=1", rch_w[0]);
      end
      checks++;
      if (fh_w[0] !== 16'd3) begin
         failures++;
         $display("FAIL direct_legacy_first_hit got=%0d expected=3", fh_w[0]);
      end
      checks++;
      if (hc_w[0] !== 16'd1) begin
         failures++;
         $display("FAIL direct_legacy_hit_count got=%0d expected=1", hc_w[0]);
      end
      en_r[0] = 1'b0;

      // Counter mode: upper bits count and wrap, bit 0 stays 1 with a=0; target 0000 hit at cycle 0.
      en_r[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         expect_v("counter_state", 1, F_ST, {12'd0, cnt_seq[i]});
         if (i == 0) begin
            expect_v("counter_reached", 1, F_RCH, 16'd1);
            expect_v("counter_first_hit", 1, F_FH, 16'd0);
         end
         flush();
      end
      expect_v("counter_cc", 1, F_CC, 16'd8);
      expect_v("counter_hits", 1, F_HC, 16'd1);
      flush();
      en_r[1] = 1'b0;

      // Shift mode: load 0001 (load beats en), then shift with a=1, then a=0.
      ld_r[2] = 1'b1;
      ls_r[2] = 4'b0001;
      en_r[2] = 1'b1;
      step();
      expect_v("shift_load", 2, F_ST, 16'h1);
      expect_v("shift_load_cc", 2, F_CC, 16'd0);
      flush();
      ld_r[2] = 1'b0;
      a_r[2]  = 1'b1;
      step(); expect_v("shift_a1", 2, F_ST, 16'h2); expect_v("shift_cc", 2, F_CC, 16'd1); flush();
      a_r[2] = 1'b0;
      step(); expect_v("shift_a0", 2, F_ST, 16'h5); expect_v("shift_hit", 2, F_HIT, 16'd1); flush();
      checks++;
      if (st_w[2] !== 4'h5) begin
         failures++;
         $display("FAIL direct_shift_state got=%0h expected=5", st_w[2]);
      end
      en_r[2] = 1'b0;

      // Load and hold: toggle 0000 -> 1111 -> 0001 -> 1111, then load 0110 while hit=1.
      en_r[4] = 1'b1;
      step(); expect_v("hold_s1", 4, F_ST, 16'hF); flush();
      step();
      expect_v("hold_s2", 4, F_ST, 16'h1);
      expect_v("hold_reached", 4, F_RCH, 16'd1);
      expect_v("hold_first_hit", 4, F_FH, 16'd1);
      flush();
      step(); expect_v("hold_s3", 4, F_ST, 16'hF); expect_v("hold_hc_once", 4, F_HC, 16'd1); flush();
      ld_r[4] = 1'b1;
      ls_r[4] = 4'b0110;
      step();
      expect_v("load_state", 4, F_ST, 16'h6);
      expect_v("load_cc", 4, F_CC, 16'd0);
      expect_v("load_hc", 4, F_HC, 16'd0);
      expect_v("load_fh", 4, F_FH, 16'd0);
      expect_v("load_reached", 4, F_RCH, 16'd0);
      flush();
      ld_r[4] = 1'b0;
      en_r[4] = 1'b0;
      repeat (5) step();
      expect_v("hold_state", 4, F_ST, 16'h6);
      expect_v("hold_cc", 4, F_CC, 16'd0);
      flush();
      tg_r[4] = 4'b0110;
      #1;
      expect_v("hold_target_hit", 4, F_HIT, 16'd1);
      expect_v("hold_hc_unchanged", 4, F_HC, 16'd0);
      flush();
      en_r[4] = 1'b1;
      step();
      expect_v("after_hold_state", 4, F_ST, 16'h9);
      expect_v("after_hold_hc", 4, F_HC, 16'd1);
      expect_v("after_hold_reached", 4, F_RCH, 16'd1);
      expect_v("after_hold_fh", 4, F_FH, 16'd0);
      expect_v("after_hold_cc", 4, F_CC, 16'd1);
      flush();
      en_r[4] = 1'b0;

      // Saturation with CW=4: unreachable target, then target tracking the state.
      en_r[3] = 1'b1;
      repeat (20) step();
      expect_v("sat_cc", 3, F_CC, 16'd15);
      expect_v("sat_unreached", 3, F_RCH, 16'd0);
      expect_v("sat_no_hits", 3, F_HC, 16'd0);
      flush();
      checks++;
      if (cc3 !== 4'd15) begin
         failures++;
         $display("FAIL direct_sat_cc got=%0d expected=15", cc3);
      end
      ld_r[3] = 1'b1;
      ls_r[3] = 4'b0000;
      step();
      ld_r[3] = 1'b0;
      m = 4'b0000;
      for (int i = 0; i < 20; i++) begin
         tg_r[3] = m;
         step();
         m = tog4(m, 1'b0);
      end
      expect_v("sat_hc", 3, F_HC, 16'd15);
      expect_v("sat_cc2", 3, F_CC, 16'd15);
      expect_v("sat_reached", 3, F_RCH, 16'd1);
      expect_v("sat_fh", 3, F_FH, 16'd0);
      expect_v("sat_state", 3, F_ST, {12'd0, m});
      flush();
      checks++;
      if (hc3 !== 4'd15) begin
         failures++;
         $display("FAIL direct_sat_hc got=%0d expected=15", hc3);
      end
      en_r[3] = 1'b0;

      // Async reset mid-cycle on a running legacy instance.
      a_r[0]  = 1'b0;
      en_r[0] = 1'b1;
      step();
      step();
      #1;
      reset = 1'b1;
      #1;
      expect_v("areset_state", 0, F_ST, 16'd0);
      expect_v("areset_reached", 0, F_RCH, 16'd0);
      expect_v("areset_hc", 0, F_HC, 16'd0);
      expect_v("areset_fh", 0, F_FH, 16'd0);
      expect_v("areset_cc", 0, F_CC, 16'd0);
      expect_v("areset_sat_cc", 3, F_CC, 16'd0);
      flush();
      #3;
      reset = 1'b0;
      step();
      step();
      expect_v("post_reset_cc", 0, F_CC, 16'd2);
      expect_v("post_reset_state", 0, F_ST, 16'd1);
      flush();
      checks++;
      if (cc_w[0] !== 16'd2) begin
         failures++;
         $display("FAIL direct_post_reset_cc got=%0d expected=2", cc_w[0]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
